// File: rtl/fusion_issue_fifo.sv
// fusion_issue_fifo: circular buffer between the fusion scan stage and issue.
// Accepts up to two (possibly fused) entries per cycle and issues one; no input-to-output bypass.
`default_nettype none

package config_pkg;
  typedef struct packed {
    int unsigned XLEN;
  } cva6_cfg_t;
  localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 0};
endpackage

module fusion_issue_fifo #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter type scoreboard_entry_t = logic,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  scoreboard_entry_t [1:0]      instruction_i,
  input  logic [1:0]                   instruction_valid_i,
  output logic                         ready_o,
  output scoreboard_entry_t            issue_instr_o,
  output logic                         issue_valid_o,
  input  logic                         issue_ack_i,
  output logic                         fused_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fusion_issue_fifo: DEPTH must be a power of two and at least 4");
  end
  if (CVA6Cfg.XLEN != 0 && CVA6Cfg.XLEN != 32 && CVA6Cfg.XLEN != 64) begin : g_bad_cfg
    $error("fusion_issue_fifo: unsupported XLEN in CVA6Cfg");
  end

  scoreboard_entry_t storage [DEPTH];
  logic [PTR_W-1:0]  rptr;
  logic [PTR_W-1:0]  wptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  logic [1:0]        push_num;
  logic [CNT_W-1:0]  count_next;

  // Two free slots are always required, so a full-width push can never overflow.
  assign ready_o       = (count <= CNT_W'(DEPTH - 2));
  assign push          = ready_o && !flush_i;
  assign push_num      = {1'b0, instruction_valid_i[0]} + {1'b0, instruction_valid_i[1]};
  assign issue_valid_o = (count != '0);
  assign pop           = issue_ack_i && issue_valid_o && !flush_i;
  assign count_next    = count + CNT_W'(push ? push_num : 2'd0) - CNT_W'(pop);
  assign issue_instr_o = storage[rptr];
  assign count_o       = count;

  // A plain (non-struct) entry type carries no fusion marker.
  if ($bits(scoreboard_entry_t) > 1) begin : g_fused
    assign fused_o = issue_valid_o && (issue_instr_o.is_fusion != 2'b00);
  end else begin : g_plain
    assign fused_o = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      if (push) begin
        wptr <= wptr + PTR_W'(push_num);
      end
      count <= count_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      unique case (instruction_valid_i)
        2'b11: begin
          storage[wptr]              <= instruction_i[0];
          storage[wptr + PTR_W'(1)]  <= instruction_i[1];
        end
        2'b01:   storage[wptr] <= instruction_i[0];
        2'b10:   storage[wptr] <= instruction_i[1];
        default: ;
      endcase
    end
  end

  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (count <= CNT_W'(DEPTH));
      assert (!(issue_ack_i && !flush_i && count == '0) || !pop);
      assert (!(push && ({1'b0, count} + (CNT_W + 1)'(push_num) > (CNT_W + 1)'(DEPTH))));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fusion_issue_fifo.sv
// ============================================================================
// Module      : tb_fusion_issue_fifo
// Description : Directed checks of fusion_issue_fifo with DEPTH=4 and a
//               struct entry type.
// Revision    : 1.2
// ============================================================================
`default_nettype none

module tb_fusion_issue_fifo;

    localparam int unsigned C_WRAP_LIMIT = 40;
    localparam int unsigned C_WATCHDOG   = 100000;

    typedef struct packed {
        logic [1:0]  is_fusion;
        logic [31:0] result;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } entry_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    entry_t [1:0] instr;
    logic [1:0]   valid;
    logic         ready;
    entry_t       issue_instr;
    logic         issue_valid;
    logic         ack;
    logic         fused;
    logic [2:0]   count;

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    fusion_issue_fifo #(
        .scoreboard_entry_t (entry_t),
        .DEPTH              (4)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .flush_i             (flush),
        .instruction_i       (instr),
        .instruction_valid_i (valid),
        .ready_o             (ready),
        .issue_instr_o       (issue_instr),
        .issue_valid_o       (issue_valid),
        .issue_ack_i         (ack),
        .fused_o             (fused),
        .count_o             (count)
    );

    always #5 clk = ~clk;

    function automatic entry_t mk(input logic [1:0] f, input logic [31:0] r);
        entry_t e;
        e.is_fusion = f;
        e.result    = r;
        e.rs1       = r[4:0];
        e.rs2       = r[9:5];
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #(C_WATCHDOG);
        if (!done) begin
            errors++;
            $error("FAIL watchdog expired after %0d time units", C_WATCHDOG);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        entry_t a, b, f, c, t, u;
        entry_t p [4];
        entry_t q [$];
        int src, cyc;
        bit accept, popd;

        rst_n = 1'b0; flush = 1'b0; valid = 2'b00; ack = 1'b0;
        instr[0] = '0; instr[1] = '0;
        a = mk(2'b00, 32'h0000_00A0);
        b = mk(2'b01, 32'h0000_00B1);
        f = mk(2'b11, 32'hDEAD_BEEF);
        c = mk(2'b00, 32'h0000_0C0C);
        t = mk(2'b10, 32'h1234_5678);
        u = mk(2'b00, 32'h0BAD_F00D);
        for (int i = 0; i < 4; i++) p[i] = mk(2'b00, 32'h100 + i);

        tick(); tick();
        checks++; if (issue_valid !== 1'b0) begin errors++; $error("FAIL rst_valid observed=%0h", issue_valid); end
        checks++; if (fused !== 1'b0) begin errors++; $error("FAIL rst_fused observed=%0h", fused); end
        checks++; if (count !== 3'd0) begin errors++; $error("FAIL rst_count observed=%0h", count); end
        checks++; if (ready !== 1'b1) begin errors++; $error("FAIL rst_ready observed=%0h", ready); end
        rst_n = 1'b1;

        // Dual push, then drain in order.
        instr[0] = a; instr[1] = b; valid = 2'b11;
        tick();
        valid = 2'b00;
        checks++; if (count !== 3'd2) begin errors++; $error("FAIL ab_count observed=%0h", count); end
        checks++; if (issue_instr !== a) begin errors++; $error("FAIL ab_head observed=%0h", issue_instr); end
        checks++; if (fused !== 1'b0) begin errors++; $error("FAIL ab_fused observed=%0h", fused); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++; if (issue_instr !== b) begin errors++; $error("FAIL b_head observed=%0h", issue_instr); end
        checks++; if (fused !== 1'b1) begin errors++; $error("FAIL b_fused observed=%0h", fused); end
        checks++; if (count !== 3'd1) begin errors++; $error("FAIL b_count observed=%0h", count); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++; if (issue_valid !== 1'b0) begin errors++; $error("FAIL ab_empty observed=%0h", issue_valid); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $error("FAIL empty_ack_count observed=%0h", count); end

        // Lone fused entry in slot 0, then lone slot 1.
        instr[0] = f; valid = 2'b01;
        tick();
        valid = 2'b00;
        checks++; if (count !== 3'd1) begin errors++; $error("FAIL f_count observed=%0h", count); end
        checks++; if (fused !== 1'b1) begin errors++; $error("FAIL f_fused observed=%0h", fused); end
        checks++; if (issue_instr !== f) begin errors++; $error("FAIL f_entry observed=%0h", issue_instr); end
        instr[0] = a; instr[1] = c; valid = 2'b10; ack = 1'b1;
        tick();
        valid = 2'b00;
        checks++; if (count !== 3'd1) begin errors++; $error("FAIL c_count observed=%0h", count); end
        checks++; if (issue_instr !== c) begin errors++; $error("FAIL c_head observed=%0h", issue_instr); end
        checks++; if (fused !== 1'b0) begin errors++; $error("FAIL c_fused observed=%0h", fused); end
        tick();
        ack = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $error("FAIL c_empty observed=%0h", count); end

        // Fill to DEPTH and hold off the third push.
        instr[0] = p[0]; instr[1] = p[1]; valid = 2'b11;
        tick();
        instr[0] = p[2]; instr[1] = p[3];
        tick();
        checks++; if (count !== 3'd4) begin errors++; $error("FAIL full_count observed=%0h", count); end
        checks++; if (ready !== 1'b0) begin errors++; $error("FAIL full_ready observed=%0h", ready); end
        instr[0] = a; instr[1] = b;
        tick();
        checks++; if (count !== 3'd4) begin errors++; $error("FAIL held_count observed=%0h", count); end
        checks++; if (issue_instr !== p[0]) begin errors++; $error("FAIL held_head observed=%0h", issue_instr); end
        ack = 1'b1;
        tick();
        checks++; if (count !== 3'd3) begin errors++; $error("FAIL ack1_count observed=%0h", count); end
        checks++; if (ready !== 1'b0) begin errors++; $error("FAIL ack1_ready observed=%0h", ready); end
        checks++; if (issue_instr !== p[1]) begin errors++; $error("FAIL ack1_head observed=%0h", issue_instr); end
        tick();
        valid = 2'b00; ack = 1'b0;
        checks++; if (count !== 3'd2) begin errors++; $error("FAIL ack2_count observed=%0h", count); end
        checks++; if (ready !== 1'b1) begin errors++; $error("FAIL ack2_ready observed=%0h", ready); end
        checks++; if (issue_instr !== p[2]) begin errors++; $error("FAIL ack2_head observed=%0h", issue_instr); end

        // Simultaneous pop and dual push at count 2.
        instr[0] = t; instr[1] = u; valid = 2'b11; ack = 1'b1;
        tick();
        valid = 2'b00; ack = 1'b0;
        checks++; if (count !== 3'd3) begin errors++; $error("FAIL pp_count observed=%0h", count); end
        checks++; if (issue_instr !== p[3]) begin errors++; $error("FAIL pp_head observed=%0h", issue_instr); end
        ack = 1'b1;
        tick();
        checks++; if (issue_instr !== t) begin errors++; $error("FAIL pp_t observed=%0h", issue_instr); end
        tick();
        checks++; if (issue_instr !== u) begin errors++; $error("FAIL pp_u observed=%0h", issue_instr); end
        tick();
        ack = 1'b0;
        checks++; if (issue_valid !== 1'b0) begin errors++; $error("FAIL pp_empty observed=%0h", issue_valid); end

        // Ten entries streamed through with a continuous ack, crossing the wrap point.
        src = 0; cyc = 0;
        while ((src < 10 || q.size() != 0) && cyc < C_WRAP_LIMIT) begin
            checks++;
            if (count !== 3'(q.size())) begin
                errors++;
                $error("FAIL wrap_count observed=%0h expected=%0h", count, q.size());
            end
            checks++;
            if (ready !== (q.size() <= 2)) begin
                errors++;
                $error("FAIL wrap_ready observed=%0h", ready);
            end
            if (q.size() != 0) begin
                checks++;
                if (issue_instr !== q[0]) begin
                    errors++;
                    $error("FAIL wrap_head observed=%0h expected=%0h", issue_instr, q[0]);
                end
            end
            if (src < 10) begin
                instr[0] = mk(2'b00, 32'h200 + src);
                instr[1] = mk(2'b01, 32'h201 + src);
                valid = 2'b11;
            end else begin
                valid = 2'b00;
            end
            ack = 1'b1;
            accept = (q.size() <= 2) && (src < 10);
            popd = (q.size() != 0);
            tick();
            if (popd) void'(q.pop_front());
            if (accept) begin
                q.push_back(mk(2'b00, 32'h200 + src));
                q.push_back(mk(2'b01, 32'h201 + src));
                src += 2;
            end
            cyc++;
        end
        valid = 2'b00; ack = 1'b0;
        checks++;
        if (cyc >= C_WRAP_LIMIT) begin
            errors++;
            $error("FAIL wrap_done timed out after %0d cycles (sent=%0d left=%0d)",
                   cyc, src, q.size());
        end

        // Flush beats a push that would otherwise be accepted.
        instr[0] = a; instr[1] = b; valid = 2'b11;
        tick();
        flush = 1'b1; instr[0] = c; instr[1] = f;
        tick();
        flush = 1'b0; valid = 2'b00;
        checks++; if (count !== 3'd0) begin errors++; $error("FAIL flush2_count observed=%0h", count); end

        // Flush at count 3 with ack and push asserted.
        instr[0] = p[0]; instr[1] = p[1]; valid = 2'b11;
        tick();
        instr[0] = p[2]; valid = 2'b01;
        tick();
        checks++; if (count !== 3'd3) begin errors++; $error("FAIL pre_flush_count observed=%0h", count); end
        flush = 1'b1; ack = 1'b1; instr[0] = a; instr[1] = b; valid = 2'b11;
        tick();
        flush = 1'b0; ack = 1'b0; valid = 2'b00;
        checks++; if (count !== 3'd0) begin errors++; $error("FAIL flush_count observed=%0h", count); end
        checks++; if (issue_valid !== 1'b0) begin errors++; $error("FAIL flush_valid observed=%0h", issue_valid); end
        checks++; if (ready !== 1'b1) begin errors++; $error("FAIL flush_ready observed=%0h", ready); end
        instr[0] = t; valid = 2'b01;
        tick();
        valid = 2'b00;
        checks++; if (issue_instr !== t) begin errors++; $error("FAIL post_flush_head observed=%0h", issue_instr); end
        checks++; if (count !== 3'd1) begin errors++; $error("FAIL post_flush_count observed=%0h", count); end

        // Asynchronous reset mid-cycle.
        instr[0] = p[0]; instr[1] = p[1]; valid = 2'b11;
        tick();
        valid = 2'b00;
        checks++; if (count !== 3'd3) begin errors++; $error("FAIL pre_rst_count observed=%0h", count); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $error("FAIL arst_valid observed=%0h", issue_valid); end
        checks++; if (count !== 3'd0) begin errors++; $error("FAIL arst_count observed=%0h", count); end
        checks++; if (ready !== 1'b1) begin errors++; $error("FAIL arst_ready observed=%0h", ready); end
        checks++; if (fused !== 1'b0) begin errors++; $error("FAIL arst_fused observed=%0h", fused); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        instr[0] = u; valid = 2'b01;
        tick();
        valid = 2'b00;
        checks++; if (issue_instr !== u) begin errors++; $error("FAIL post_rst_head observed=%0h", issue_instr); end
        checks++; if (count !== 3'd1) begin errors++; $error("FAIL post_rst_count observed=%0h", count); end

        done = 1'b1;
        if (errors != 0) begin
            $error("FAIL %0d of %0d checks failed", errors, checks);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fusion_issue_fifo.md
FUSION_ISSUE_FIFO -- requirements
Module: fusion_issue_fifo

Interface
REQ-001 SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, CVA6 configuration.
REQ-002 SHALL have parameter scoreboard_entry_t, default logic, decoded/fused instruction entry type.
REQ-003 SHALL have parameter DEPTH, default 4, number of entries; power of two, >= 4.
REQ-004 SHALL have port clk_i  input  1  clock; single clock domain, all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port flush_i  input  1  synchronous flush of all entries.
REQ-007 SHALL have port instruction_i  input  scoreboard_entry_t[1:0]  entries from the fusion scan stage; slot 0 is older.
REQ-008 SHALL have port instruction_valid_i  input  2  per-slot valid; slot 1 is invalid when the fusion stage has absorbed it into slot 0.
REQ-009 SHALL have port ready_o  output  1  the FIFO can accept both slots this cycle.
REQ-010 SHALL have port issue_instr_o  output  scoreboard_entry_t  head entry toward issue.
REQ-011 SHALL have port issue_valid_o  output  1  head entry is valid.
REQ-012 SHALL have port issue_ack_i  input  1  issue consumes the head entry.
REQ-013 SHALL have port fused_o  output  1  head entry is a fused pair (is_fusion != 0).
REQ-014 SHALL have port count_o  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-015 SHALL be a circular buffer with read pointer, write pointer and occupancy counter; pointers wrap modulo DEPTH.
REQ-016 SHALL assert ready_o combinationally when count_o <= DEPTH-2, independent of issue_ack_i.
REQ-017 SHALL accept a push only when ready_o=1 and flush_i=0; with ready_o=0 the inputs are ignored, and the upstream stage holds them.
REQ-018 SHALL write valid slots in order: slot 0 at wptr and slot 1 at wptr+1 when both are valid; a lone valid slot, 0 or 1, goes to wptr.
REQ-019 SHALL advance wptr and count by popcount(instruction_valid_i) on an accepted push; valid=2'b00 changes nothing.
REQ-020 SHALL drive issue_valid_o = (count_o != 0) and issue_instr_o = storage[rptr], with no input-to-output bypass: an entry pushed in cycle N is visible at the earliest in cycle N+1.
REQ-021 SHALL pop on issue_ack_i=1 with issue_valid_o=1: rptr+1, count-1; issue_ack_i on an empty FIFO is ignored.
REQ-022 SHALL handle push and pop in the same cycle: count_next = count + pushed - popped, with the pushed value computed from ready_o as it was before the pop.
REQ-023 SHALL drive fused_o = issue_valid_o AND (issue_instr_o.is_fusion != 2'b00).
REQ-024 SHALL, on flush_i=1, set rptr=0, wptr=0 and count=0 at the next edge; flush_i takes precedence over a simultaneous push and pop, and issue_ack_i is ignored in that cycle.
REQ-025 SHALL never overflow (count <= DEPTH) or underflow; violation is an assertion failure in simulation.
REQ-026 SHALL NOT modify entry contents, including result, rs1, rs2 and is_fusion; the block is a pure buffer.

Reset
REQ-027 SHALL, with rst_ni low, asynchronously clear rptr, wptr and count to 0, so that issue_valid_o=0, fused_o=0, count_o=0 and ready_o=1.
REQ-028 SHALL leave entry storage unreset; storage is don't-care while the entry is not counted.
REQ-029 SHALL discard in-flight entries when reset is asserted mid-operation; the first accepted push after deassertion is written to entry 0.

Verification
REQ-030 SHALL cover: reset, then push valid=2'b11 with A,B -> next cycle count_o=2, issue_instr_o=A; ack -> B; ack -> issue_valid_o=0.
REQ-031 SHALL cover: push valid=2'b01 with fused entry F (is_fusion=2'b11) -> count_o=1, fused_o=1, F.result unchanged.
REQ-032 SHALL cover: DEPTH=4, two pushes of 2'b11 with no ack -> count_o=4, ready_o=0; a third push is held off; one ack -> count_o=3, ready_o=0; a second ack -> ready_o=1.
REQ-033 SHALL cover: count_o=2 with simultaneous ack and 2'b11 push -> count_o=3; order of issue preserved across pointer wrap over 10 pushes.
REQ-034 SHALL cover: count_o=3 with flush_i, ack and push all high -> next cycle count_o=0, issue_valid_o=0; the following push lands at entry 0.
REQ-035 SHALL cover: rst_ni dropped asynchronously mid-cycle with count_o=3 -> issue_valid_o=0 immediately, without waiting for a clock edge.
